stb_to_utf8: RTL

- HLS-style accelerator component that converts a NUL-terminated UTF-16 string in memory (`str`) into UTF-8 bytes written to `buffer0`, with at most `n` bytes including the terminator.
- Inverse of the existing stb_from_utf8 component; same call/return handshake and single Avalon-MM read/write master.
- Returns `buffer0` on success, 0 on overflow or on a stray low surrogate.

---
 rtl/stb_to_utf8.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stb_to_utf8.sv
`timescale 1ns/1ps
// stb_to_utf8: converts a NUL-terminated UTF-16 string into at most n UTF-8 bytes over one Avalon-MM master.
// Latency: RD + READ_LATENCY + CLASS cycles per source unit, plus one cycle per byte written.
// Backpressure: done/returndata held while stall is high; start ignored while busy. STB_TO_UTF8_STRICT_EN rejects bad low surrogates.
module stb_to_utf8 #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        stall,
   output logic [63:0] returndata,
   input  logic [63:0] buffer0,
   input  logic [63:0] str,
   input  logic [31:0] n,
   output logic [63:0] avmm_0_rw_address,
   output logic [7:0]  avmm_0_rw_byteenable,
   output logic        avmm_0_rw_read,
   input  logic [63:0] avmm_0_rw_readdata,
   output logic        avmm_0_rw_write,
   output logic [63:0] avmm_0_rw_writedata
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_RWAIT, S_CLASS, S_RD2, S_RWAIT2, S_WR, S_NUL, S_FAIL, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] buf_q, buf_d;
   logic [63:0] str_q, str_d;
   logic [63:0] ret_q, ret_d;
   logic [32:0] limit_q, limit_d;
   logic [32:0] i_q, i_d;
   logic [62:0] k_q, k_d;
   logic [15:0] u_q, u_d;
   logic [31:0] pend_q, pend_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  lat_q, lat_d;
   logic [1:0]  lane_q, lane_d;
   logic        pair_q, pair_d;

   logic [62:0] rd_k;
   logic [63:0] rd_addr;
   logic [63:0] dst_addr;
   logic [15:0] rd_unit;
   logic        lat_hit;
   logic [25:0] cp;
   logic [2:0]  need;
   logic [31:0] enc;
   logic        is_hi;
   logic        is_lo;
   logic [32:0] i_need;
   logic        fits;
   logic        lo_bad;
   logic        unused_bits;

   assign rd_k        = (state_q == S_RD2) ? k_q + 63'd1 : k_q;
   assign rd_addr     = str_q + {rd_k, 1'b0};
   assign dst_addr    = buf_q + {31'd0, i_q};
   assign rd_unit     = avmm_0_rw_readdata[{lane_q, 4'b0000} +: 16];
   assign lat_hit     = (lat_q == 3'(READ_LATENCY));
   assign unused_bits = rd_addr[0];

   // Only code point bits 25:0 reach the emitted bytes, so 26-bit wrap matches 32-bit wrap.
   assign cp = (({10'd0, u_q} - 26'h0D800) << 10) + ({10'd0, rd_unit} - 26'h0DC00) + 26'h10000;

`ifdef STB_TO_UTF8_STRICT_EN
   assign lo_bad = (rd_unit < 16'hDC00) || (rd_unit > 16'hDFFF);
`else
   assign lo_bad = 1'b0;
`endif

   always_comb begin
      need  = 3'd0;
      enc   = 32'd0;
      is_hi = 1'b0;
      is_lo = 1'b0;
      if (u_q < 16'h0080) begin
         need = 3'd1;
         enc  = {u_q[7:0], 24'd0};
      end else if (u_q < 16'h0800) begin
         need = 3'd2;
         enc  = {8'hC0 + {3'b000, u_q[10:6]}, 8'h80 + {2'b00, u_q[5:0]}, 16'd0};
      end else if (u_q >= 16'hD800 && u_q < 16'hDC00) begin
         need  = 3'd4;
         is_hi = 1'b1;
      end else if (u_q >= 16'hDC00 && u_q < 16'hE000) begin
         is_lo = 1'b1;
      end else begin
         need = 3'd3;
         enc  = {8'hE0 + {4'b0000, u_q[15:12]}, 8'h80 + {2'b00, u_q[11:6]},
                 8'h80 + {2'b00, u_q[5:0]}, 8'd0};
      end
   end

   // limit reserves the terminator byte; n may be zero or negative.
   assign i_need = i_q + {30'd0, need};
   assign fits   = !($signed(i_need) > $signed(limit_q));

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      str_d    = str_q;
      ret_d    = ret_q;
      limit_d  = limit_q;
      i_d      = i_q;
      k_d      = k_q;
      u_d      = u_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      lat_d    = lat_q;
      lane_d   = lane_q;
      pair_d   = pair_q;
      avmm_0_rw_address    = 64'd0;
      avmm_0_rw_byteenable = 8'd0;
      avmm_0_rw_read       = 1'b0;
      avmm_0_rw_write      = 1'b0;
      avmm_0_rw_writedata  = 64'd0;
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      returndata = (state_q == S_DONE) ? ret_q : 64'd0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               buf_d   = buffer0;
               str_d   = str;
               limit_d = {n[31], n} - 33'd1;
               i_d     = 33'd0;
               k_d     = 63'd0;
               state_d = S_RD;
            end
         end
         S_RD, S_RD2: begin
            avmm_0_rw_read       = 1'b1;
            avmm_0_rw_address    = {rd_addr[63:3], 3'b000};
            avmm_0_rw_byteenable = 8'h03 << {rd_addr[2:1], 1'b0};
            lane_d  = rd_addr[2:1];
            lat_d   = 3'd1;
            state_d = (state_q == S_RD) ? S_RWAIT : S_RWAIT2;
         end
         S_RWAIT: begin
            if (lat_hit) begin
               u_d     = rd_unit;
               state_d = S_CLASS;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_CLASS: begin
            if (u_q == 16'h0000) begin
               state_d = S_NUL;
            end else if (is_lo || !fits) begin
               state_d = S_FAIL;
            end else if (is_hi) begin
               pair_d  = 1'b1;
               state_d = S_RD2;
            end else begin
               pair_d  = 1'b0;
               pend_d  = enc;
               cnt_d   = need;
               state_d = S_WR;
            end
         end
         S_RWAIT2: begin
            if (!lat_hit) begin
               lat_d = lat_q + 3'd1;
            end else if (lo_bad) begin
               state_d = S_FAIL;
            end else begin
               pend_d  = {8'hF0 + cp[25:18], 8'h80 + {2'b00, cp[17:12]},
                          8'h80 + {2'b00, cp[11:6]}, 8'h80 + {2'b00, cp[5:0]}};
               cnt_d   = 3'd4;
               k_d     = k_q + 63'd2;
               state_d = S_WR;
            end
         end
         S_WR: begin
            avmm_0_rw_write      = 1'b1;
            avmm_0_rw_address    = {dst_addr[63:3], 3'b000};
            avmm_0_rw_byteenable = 8'h01 << dst_addr[2:0];
            avmm_0_rw_writedata  = {8{pend_q[31:24]}};
            i_d    = i_q + 33'd1;
            pend_d = {pend_q[23:0], 8'd0};
            cnt_d  = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = S_RD;
               if (!pair_q) k_d = k_q + 63'd1;
            end
         end
         S_NUL: begin
            avmm_0_rw_write      = 1'b1;
            avmm_0_rw_address    = {dst_addr[63:3], 3'b000};
            avmm_0_rw_byteenable = 8'h01 << dst_addr[2:0];
            ret_d   = buf_q;
            state_d = S_DONE;
         end
         S_FAIL: begin
            ret_d   = 64'd0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!stall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         buf_q   <= 64'd0;
         str_q   <= 64'd0;
         ret_q   <= 64'd0;
         limit_q <= 33'd0;
         i_q     <= 33'd0;
         k_q     <= 63'd0;
         u_q     <= 16'd0;
         pend_q  <= 32'd0;
         cnt_q   <= 3'd0;
         lat_q   <= 3'd0;
         lane_q  <= 2'd0;
         pair_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         str_q   <= str_d;
         ret_q   <= ret_d;
         limit_q <= limit_d;
         i_q     <= i_d;
         k_q     <= k_d;
         u_q     <= u_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         lane_q  <= lane_d;
         pair_q  <= pair_d;
      end
   end

   a_no_rw_overlap: assert property (@(posedge clock) disable iff (!resetn)
      !(avmm_0_rw_read && avmm_0_rw_write));

endmodule
